dmem_wbuf_responder: RTL and testbench

- Responder side of the CPU data-memory port. It receives memwriteM, aluoutM and writedataM from the pipeline and returns readdataM.
- Stores go into a small posted write buffer. The buffer drains into a single-port word RAM on cycles when the port is not needed for a load.
- Loads are answered combinationally in the M stage. Pending buffered stores are forwarded, so the pipeline always sees program order.
- A stall request tells the pipeline when a store cannot be accepted.

---
 rtl/dmem_wbuf_responder_if.sv | 28 ++
 rtl/dmem_wbuf_responder.sv | 87 ++++++++
 tb/tb_dmem_wbuf_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_wbuf_responder_if.sv
// Data-memory port between the M stage and the write-buffered responder.
// The master is the pipeline side; the slave answers loads and raises stalls.
interface dmem_wbuf_responder_if;
   logic        memreadM;
   logic        memwriteM;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic [31:0] readdataM;
   logic        stallM_req;

   modport master (
      output memreadM,
      output memwriteM,
      output aluoutM,
      output writedataM,
      input  readdataM,
      input  stallM_req
   );

   modport slave (
      input  memreadM,
      input  memwriteM,
      input  aluoutM,
      input  writedataM,
      output readdataM,
      output stallM_req
   );
endinterface

// File: rtl/dmem_wbuf_responder.sv
// Data-memory responder: posted store buffer draining into a single-port
// word RAM, with zero-latency loads that forward pending stores.
module dmem_wbuf_responder #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   dmem_wbuf_responder_if.slave bus,
   output logic             wbuf_empty,
   output logic [CNT_W-1:0] wbuf_count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  headQ;
   logic [PTR_W-1:0]  tailQ;
   logic [CNT_W-1:0]  countQ;
   logic [ADDR_W-1:0] addrQ [DEPTH];
   logic [31:0]       dataQ [DEPTH];
   logic [31:0]       ram   [2**ADDR_W];

   logic [ADDR_W-1:0] waddr;
   logic              full;
   logic              doEnq;
   logic              doDrain;
   logic              fwdHit;
   logic [31:0]       fwdData;
   logic              unusedAddr;

   assign waddr      = bus.aluoutM[ADDR_W+1:2];
   assign unusedAddr = ^{bus.aluoutM[31:ADDR_W+2], bus.aluoutM[1:0]};

   assign full    = (countQ == CNT_W'(DEPTH));
   assign doEnq   = bus.memwriteM & ~full;
   // Loads own the single RAM port, so draining waits for a load-free cycle.
   assign doDrain = (countQ != '0) & ~bus.memreadM;

   assign bus.stallM_req = bus.memwriteM & full;
   assign wbuf_count     = countQ;
   assign wbuf_empty     = (countQ == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         headQ  <= '0;
         tailQ  <= '0;
         countQ <= '0;
      end else begin
         if (doEnq)
            tailQ <= tailQ + PTR_W'(1);
         if (doDrain)
            headQ <= headQ + PTR_W'(1);
         countQ <= countQ + CNT_W'(doEnq) - CNT_W'(doDrain);
      end
   end

   always_ff @(posedge clk) begin
      if (doEnq) begin
         addrQ[tailQ] <= waddr;
         dataQ[tailQ] <= bus.writedataM;
      end
   end

   always_ff @(posedge clk) begin
      if (doDrain && rst)
         ram[addrQ[headQ]] <= dataQ[headQ];
   end

   // Walk oldest to youngest so the last match is the youngest store.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < countQ &&
             addrQ[headQ + PTR_W'(k)] == waddr) begin
            fwdHit  = 1'b1;
            fwdData = dataQ[headQ + PTR_W'(k)];
         end
      end
   end

   always_comb begin
      bus.readdataM = '0;
      if (bus.memreadM)
         bus.readdataM = fwdHit ? fwdData : ram[waddr];
   end
endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Directed bench for dmem_wbuf_responder: a program-order memory model
// feeds a queue of expected load data that is popped as the DUT answers.
module tb_dmem_wbuf_responder;
   logic       clk;
   logic       rst;
   logic       wbuf_empty;
   logic [2:0] wbuf_count;

   dmem_wbuf_responder_if bus ();

   dmem_wbuf_responder #(
      .ADDR_W(10),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .wbuf_empty(wbuf_empty),
      .wbuf_count(wbuf_count)
   );

   int          nTests = 0;
   int          nFail  = 0;
   logic [31:0] modelMem [1024];
   logic [31:0] expQ [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkCount(input int exp);
      check("count", 32'(wbuf_count), 32'(exp));
      check("empty", 32'(wbuf_empty), 32'(exp == 0));
   endtask

   // Drive one cycle at the negedge, check mid-cycle, end at next negedge.
   task automatic step(input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic expStall);
      logic [9:0] wa;
      wa = addr[11:2];
      bus.memreadM   = rd;
      bus.memwriteM  = wr;
      bus.aluoutM    = addr;
      bus.writedataM = data;
      expQ.push_back(rd ? modelMem[wa] : 32'h0);
      #1;
      check("rdata", bus.readdataM, expQ.pop_front());
      check("stall", 32'(bus.stallM_req), 32'(expStall));
      if (wr && !expStall)
         modelMem[wa] = data;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic load(input logic [31:0] addr);
      step(1'b1, 1'b0, addr, 32'h0, 1'b0);
   endtask

   task automatic drainOut(input int budget);
      int n;
      n = 0;
      while (wbuf_count != 3'd0 && n < budget) begin
         idle();
         n++;
      end
      checkCount(0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         modelMem[i] = 32'h0;
      rst            = 1'b0;
      bus.memreadM   = 1'b0;
      bus.memwriteM  = 1'b0;
      bus.aluoutM    = 32'h0;
      bus.writedataM = 32'h0;

      // Reset state
      @(negedge clk);
      checkCount(0);
      check("rst_stall", 32'(bus.stallM_req), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      checkCount(0);
      load(32'h40);

      // Single store drains on the next free cycle
      step(1'b0, 1'b1, 32'h10, 32'h12345678, 1'b0);
      checkCount(1);
      idle();
      checkCount(0);
      load(32'h10);

      // Forwarding while loads hold off the drain
      step(1'b1, 1'b1, 32'h20, 32'hAAAA0001, 1'b0);
      checkCount(1);
      step(1'b1, 1'b1, 32'h20, 32'hAAAA0002, 1'b0);
      checkCount(2);
      for (int i = 0; i < 3; i++) begin
         load(32'h20);
         checkCount(2);
      end
      idle();
      checkCount(1);
      idle();
      checkCount(0);
      load(32'h20);

      // Fill under load pressure, then stall one cycle
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 32'h200 + 32'(4 * i),
              32'hB000_0000 + 32'(i), 1'b0);
      checkCount(4);
      load(32'h204);
      checkCount(4);
      step(1'b0, 1'b1, 32'h210, 32'hB000_0004, 1'b1);
      checkCount(3);
      step(1'b0, 1'b1, 32'h210, 32'hB000_0004, 1'b0);
      checkCount(3);
      drainOut(10);
      for (int i = 0; i < 5; i++)
         load(32'h200 + 32'(4 * i));

      // Pointer wrap-around with idle gaps
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 32'(4 * i), 32'(i), 1'b0);
         idle();
      end
      checkCount(0);
      for (int i = 0; i < 10; i++)
         load(32'(4 * i));

      // Reset with stores still pending discards them
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 32'h300 + 32'(4 * i),
              32'hC000_0000 + 32'(i), 1'b0);
      checkCount(3);
      bus.memreadM  = 1'b0;
      bus.memwriteM = 1'b0;
      rst = 1'b0;
      #1;
      checkCount(0);
      for (int i = 0; i < 3; i++)
         modelMem[10'h0C0 + 10'(i)] = 32'h0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++)
         load(32'h300 + 32'(4 * i));
      load(32'h200);
      checkCount(0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
